// File: rtl/piksel_besleyici_pkg.sv
// ----------------------------------------------------------------------------
// piksel_besleyici_pkg
// Shared constants for the pixel feeder (the "sabitler" set):
//   - GRV*_KOD : 3-bit task codes handed to gorev_birimi on basla_o
//   - pb_durum_t : feeder FSM state encodings PB_BOSTA/PB_BASLA/PB_AKIS/PB_BITTI
//   - VARSAYILAN_GENISLIK / VARSAYILAN_YUKSEKLIK : default 320x240 frame
// No ports (package).
// ----------------------------------------------------------------------------
package piksel_besleyici_pkg;

   localparam logic [2:0] GRV0_KOD = 3'd0;
   localparam logic [2:0] GRV1_KOD = 3'd1;
   localparam logic [2:0] GRV2_KOD = 3'd2;
   localparam logic [2:0] GRV3_KOD = 3'd3;
   localparam logic [2:0] GRV4_KOD = 3'd4;
   localparam logic [2:0] GRV5_KOD = 3'd5;
   localparam logic [2:0] GRV6_KOD = 3'd6;
   localparam logic [2:0] GRV7_KOD = 3'd7;

   typedef enum logic [1:0] {
      PB_BOSTA = 2'b00,
      PB_BASLA = 2'b01,
      PB_AKIS  = 2'b10,
      PB_BITTI = 2'b11
   } pb_durum_t;

   localparam int VARSAYILAN_GENISLIK  = 320;
   localparam int VARSAYILAN_YUKSEKLIK = 240;

endpackage

// File: rtl/piksel_besleyici_kelime_tamponu.sv
// ----------------------------------------------------------------------------
// kelime_tamponu
// Two-entry 32-bit word FIFO with a byte-select read pointer. The head word
// is read out one byte at a time, byte 0 ([7:0]) first; the word is popped
// when its last byte ([31:24]) is consumed.
// Ports:
//   clk_i, rstn_i   clock, asynchronous active-low reset
//   temizle_i       synchronous flush (empties FIFO, resets byte pointer)
//   yaz_i, veri_i   push a word
//   tuket_i         consume the current head byte
//   bos_o, dolu_o   empty / full flags
//   sayi_o          number of buffered words (0..2)
//   bayt_o          current head byte
//   son_bayt_o      the head word's last byte is consumed this cycle
// A push while full is accepted only when the same cycle pops a word, so a
// word arriving with the final byte of the head word loads without a bubble.
// ----------------------------------------------------------------------------
module kelime_tamponu (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        temizle_i,
   input  logic        yaz_i,
   input  logic [31:0] veri_i,
   input  logic        tuket_i,
   output logic        bos_o,
   output logic        dolu_o,
   output logic [1:0]  sayi_o,
   output logic [7:0]  bayt_o,
   output logic        son_bayt_o
);

   logic [31:0] r_kelime [2];
   logic        r_yaz_ptr;
   logic        r_oku_ptr;
   logic [1:0]  r_sayi;
   logic [1:0]  r_bayt_sec;

   logic        w_bos;
   logic        w_dolu;
   logic        w_tuket;
   logic        w_son;
   logic        w_yaz;
   logic [31:0] w_bas;

   assign w_bos   = (r_sayi == 2'd0);
   assign w_dolu  = (r_sayi == 2'd2);
   assign w_tuket = tuket_i && !w_bos;
   assign w_son   = w_tuket && (r_bayt_sec == 2'd3);
   assign w_yaz   = yaz_i && (!w_dolu || w_son);
   assign w_bas   = r_kelime[r_oku_ptr];

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_kelime[0] <= 32'h0;
         r_kelime[1] <= 32'h0;
         r_yaz_ptr   <= 1'b0;
         r_oku_ptr   <= 1'b0;
         r_sayi      <= 2'd0;
         r_bayt_sec  <= 2'd0;
      end else if (temizle_i) begin
         r_yaz_ptr   <= 1'b0;
         r_oku_ptr   <= 1'b0;
         r_sayi      <= 2'd0;
         r_bayt_sec  <= 2'd0;
      end else begin
         if (w_yaz) begin
            r_kelime[r_yaz_ptr] <= veri_i;
            r_yaz_ptr           <= ~r_yaz_ptr;
         end
         if (w_son) begin
            r_oku_ptr <= ~r_oku_ptr;
         end
         if (w_tuket) begin
            r_bayt_sec <= r_bayt_sec + 2'd1;
         end
         case ({w_yaz, w_son})
            2'b10:   r_sayi <= r_sayi + 2'd1;
            2'b01:   r_sayi <= r_sayi - 2'd1;
            default: r_sayi <= r_sayi;
         endcase
      end
   end

   always_comb begin
      bayt_o = 8'h00;
      case (r_bayt_sec)
         2'd0:    bayt_o = w_bas[7:0];
         2'd1:    bayt_o = w_bas[15:8];
         2'd2:    bayt_o = w_bas[23:16];
         default: bayt_o = w_bas[31:24];
      endcase
   end

   assign bos_o      = w_bos;
   assign dolu_o     = w_dolu;
   assign sayi_o     = r_sayi;
   assign son_bayt_o = w_son;

endmodule

// File: rtl/piksel_besleyici.sv
// ----------------------------------------------------------------------------
// piksel_besleyici
// Source-side driver of the gorev_birimi pixel stream. On baslat_i it latches
// a task code and base address, pulses basla_o with gorev_o, then fetches a
// GENISLIK x YUKSEKLIK 8-bit frame as 32-bit words and streams it byte by
// byte on etkin_o/pixel_o under stal_i backpressure.
//
// Optional feature: define PIKSEL_BESLEYICI_SAYAC_EN to add stal_sayac_o, a
// saturating count of cycles with etkin_o=1 and stal_i=1 (cleared on reset
// and on the BASLA cycle, held after the frame).
//
// Ports:
//   clk_i, rstn_i           clock, asynchronous active-low reset
//   baslat_i                start pulse (honoured only when idle)
//   gorev_kod_i             task code, sampled with baslat_i
//   taban_adres_i           4-aligned frame base byte address
//   mesgul_o, bitti_o       busy level, one-cycle done pulse
//   bel_istek_o/_adres_o    memory read request / byte address
//   bel_istek_kabul_i       request accepted this cycle
//   bel_veri_i/_gecerli_i   in-order read data, byte 0 in [7:0]
//   basla_o, gorev_o        task start pulse, latched task code
//   etkin_o, pixel_o        pixel valid / data
//   stal_i                  downstream stall
//
// Handshakes: a memory request is issued while bel_istek_o=1 and completes
// in the cycle bel_istek_kabul_i=1; bel_istek_o/bel_adres_o never change
// before that. A pixel transfers in a cycle with etkin_o=1 and stal_i=0;
// while stalled etkin_o/pixel_o hold.
// ----------------------------------------------------------------------------
module piksel_besleyici
   import piksel_besleyici_pkg::*;
#(
   parameter int GENISLIK  = VARSAYILAN_GENISLIK,
   parameter int YUKSEKLIK = VARSAYILAN_YUKSEKLIK,
   parameter int ADRES_BIT = 32
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 baslat_i,
   input  logic [2:0]           gorev_kod_i,
   input  logic [ADRES_BIT-1:0] taban_adres_i,
   output logic                 mesgul_o,
   output logic                 bitti_o,
   output logic                 bel_istek_o,
   output logic [ADRES_BIT-1:0] bel_adres_o,
   input  logic                 bel_istek_kabul_i,
   input  logic [31:0]          bel_veri_i,
   input  logic                 bel_veri_gecerli_i,
   output logic                 basla_o,
   output logic [2:0]           gorev_o,
   output logic                 etkin_o,
   output logic [7:0]           pixel_o,
   input  logic                 stal_i
`ifdef PIKSEL_BESLEYICI_SAYAC_EN
   ,
   output logic [31:0]          stal_sayac_o
`endif
);

   localparam int TOPLAM_PIKSEL = GENISLIK * YUKSEKLIK;
   localparam int TOPLAM_KELIME = TOPLAM_PIKSEL / 4;
   localparam int PB            = $clog2(TOPLAM_PIKSEL);
   localparam int KB            = $clog2(TOPLAM_KELIME + 1);
   localparam logic [PB-1:0] SON_PIKSEL    = PB'(TOPLAM_PIKSEL - 1);
   localparam logic [KB-1:0] KELIME_SAYISI = KB'(TOPLAM_KELIME);

   pb_durum_t            r_durum;
   pb_durum_t            w_sonraki;
   logic [2:0]           r_gorev;
   logic [ADRES_BIT-1:0] r_adres;
   logic [PB-1:0]        r_piksel_sayac;
   logic [KB-1:0]        r_istek_sayac;
   logic [1:0]           r_bekleyen;

   logic       w_basla;
   logic       w_mesgul;
   logic       w_bitti;
   logic       w_akis;
   logic       w_kabul_al;
   logic       w_istek;
   logic       w_kabul;
   logic       w_yaz;
   logic       w_bos;
   logic       w_dolu;
   logic [1:0] w_sayi;
   logic [7:0] w_bayt;
   logic       w_son_bayt;
   logic       w_etkin;
   logic       w_aktarim;
   logic       w_son_piksel;
   logic [2:0] w_doluluk;

   // ---------------- FSM ----------------
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_durum <= PB_BOSTA;
      end else begin
         r_durum <= w_sonraki;
      end
   end

   always_comb begin
      w_sonraki  = r_durum;
      w_basla    = 1'b0;
      w_mesgul   = 1'b0;
      w_bitti    = 1'b0;
      w_akis     = 1'b0;
      w_kabul_al = 1'b0;
      case (r_durum)
         PB_BOSTA: begin
            if (baslat_i) begin
               w_kabul_al = 1'b1;
               w_sonraki  = PB_BASLA;
            end
         end
         PB_BASLA: begin
            w_basla   = 1'b1;
            w_mesgul  = 1'b1;
            w_sonraki = PB_AKIS;
         end
         PB_AKIS: begin
            w_mesgul = 1'b1;
            w_akis   = 1'b1;
            if (w_son_piksel) begin
               w_sonraki = PB_BITTI;
            end
         end
         default: begin
            w_bitti   = 1'b1;
            w_sonraki = PB_BOSTA;
         end
      endcase
   end

   // ---------------- Fetch ----------------
   // Requests are gated only by registered counts, never by stal_i, so a
   // raised request cannot drop before it is accepted: a returning word moves
   // one unit from outstanding to buffered, leaving the sum unchanged.
   assign w_doluluk = {1'b0, r_bekleyen} + {1'b0, w_sayi};
   assign w_istek   = w_akis && (r_istek_sayac != KELIME_SAYISI) &&
                      (w_doluluk < 3'd2) && !w_dolu;
   assign w_kabul   = w_istek && bel_istek_kabul_i;
   assign w_yaz     = bel_veri_gecerli_i && w_akis && (r_bekleyen != 2'd0);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_gorev        <= 3'd0;
         r_adres        <= '0;
         r_istek_sayac  <= '0;
         r_bekleyen     <= 2'd0;
         r_piksel_sayac <= '0;
      end else begin
         if (w_kabul_al) begin
            r_gorev <= gorev_kod_i;
            r_adres <= taban_adres_i;
         end else if (w_kabul) begin
            r_adres <= r_adres + ADRES_BIT'(4);
         end

         if (w_basla) begin
            r_istek_sayac <= '0;
         end else if (w_kabul) begin
            r_istek_sayac <= r_istek_sayac + KB'(1);
         end

         if (w_basla) begin
            r_bekleyen <= 2'd0;
         end else begin
            case ({w_kabul, w_yaz})
               2'b10:   r_bekleyen <= r_bekleyen + 2'd1;
               2'b01:   r_bekleyen <= r_bekleyen - 2'd1;
               default: r_bekleyen <= r_bekleyen;
            endcase
         end

         if (w_basla) begin
            r_piksel_sayac <= '0;
         end else if (w_aktarim) begin
            r_piksel_sayac <= r_piksel_sayac + PB'(1);
         end
      end
   end

   // ---------------- Stream ----------------
   kelime_tamponu u_tampon (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .temizle_i  (w_basla),
      .yaz_i      (w_yaz),
      .veri_i     (bel_veri_i),
      .tuket_i    (w_aktarim),
      .bos_o      (w_bos),
      .dolu_o     (w_dolu),
      .sayi_o     (w_sayi),
      .bayt_o     (w_bayt),
      .son_bayt_o (w_son_bayt)
   );

   assign w_etkin   = !w_bos;
   assign w_aktarim = w_etkin && !stal_i;
   // The final pixel is always byte 3 of the final word.
   assign w_son_piksel = w_son_bayt && (r_piksel_sayac == SON_PIKSEL);

`ifdef PIKSEL_BESLEYICI_SAYAC_EN
   logic [31:0] r_stal_sayac;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_stal_sayac <= 32'h0;
      end else if (w_basla) begin
         r_stal_sayac <= 32'h0;
      end else if (w_etkin && stal_i && (r_stal_sayac != 32'hFFFF_FFFF)) begin
         r_stal_sayac <= r_stal_sayac + 32'd1;
      end
   end

   assign stal_sayac_o = r_stal_sayac;
`endif

   assign mesgul_o    = w_mesgul;
   assign bitti_o     = w_bitti;
   assign bel_istek_o = w_istek;
   assign bel_adres_o = r_adres;
   assign basla_o     = w_basla;
   assign gorev_o     = r_gorev;
   assign etkin_o     = w_etkin;
   assign pixel_o     = w_etkin ? w_bayt : 8'h00;

endmodule

// File: tb/tb_piksel_besleyici.sv
// ----------------------------------------------------------------------------
// tb_piksel_besleyici
// Bench for piksel_besleyici on a 32x4 frame (128 pixels, 32 words).
// Memory model, stall driver and output monitor run on the falling edge;
// the control sequence drives on rising edge + 1.
// ----------------------------------------------------------------------------
module tb_piksel_besleyici;
   import piksel_besleyici_pkg::*;

   localparam int TB_G   = 32;
   localparam int TB_Y   = 4;
   localparam int TB_PIK = TB_G * TB_Y;
   localparam int TB_KEL = TB_PIK / 4;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic        baslat_i;
   logic [2:0]  gorev_kod_i;
   logic [31:0] taban_adres_i;
   logic        mesgul_o;
   logic        bitti_o;
   logic        bel_istek_o;
   logic [31:0] bel_adres_o;
   logic        bel_istek_kabul_i;
   logic [31:0] bel_veri_i;
   logic        bel_veri_gecerli_i;
   logic        basla_o;
   logic [2:0]  gorev_o;
   logic        etkin_o;
   logic [7:0]  pixel_o;
   logic        stal_i;
`ifdef PIKSEL_BESLEYICI_SAYAC_EN
   logic [31:0] stal_sayac_o;
`endif

   piksel_besleyici #(
      .GENISLIK  (TB_G),
      .YUKSEKLIK (TB_Y),
      .ADRES_BIT (32)
   ) dut (
      .clk_i              (clk_i),
      .rstn_i             (rstn_i),
      .baslat_i           (baslat_i),
      .gorev_kod_i        (gorev_kod_i),
      .taban_adres_i      (taban_adres_i),
      .mesgul_o           (mesgul_o),
      .bitti_o            (bitti_o),
      .bel_istek_o        (bel_istek_o),
      .bel_adres_o        (bel_adres_o),
      .bel_istek_kabul_i  (bel_istek_kabul_i),
      .bel_veri_i         (bel_veri_i),
      .bel_veri_gecerli_i (bel_veri_gecerli_i),
      .basla_o            (basla_o),
      .gorev_o            (gorev_o),
      .etkin_o            (etkin_o),
      .pixel_o            (pixel_o),
      .stal_i             (stal_i)
`ifdef PIKSEL_BESLEYICI_SAYAC_EN
      ,
      .stal_sayac_o       (stal_sayac_o)
`endif
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [7:0]  exp_q[$];
   logic [31:0] exp_adr_q[$];
   logic [31:0] yanit_veri_q[$];
   int          yanit_zaman_q[$];

   int n_karsilastirma = 0;
   int n_hata          = 0;

   int stal_mod   = 0;   // 0: none, 1: every second cycle, 2: random
   int kabul_mod  = 0;   // 0: accept at once, 1: every third request cycle
   int gecikme    = 1;   // response latency in cycles

   int baslat_cyc, basla_cyc, ilk_istek_cyc, ilk_etkin_cyc, son_aktarim_cyc;
   int basla_sayisi, bitti_sayisi, aktarim_sayisi, teslim_sayisi;
   int istek_gorulen, stal_model;
   int bek, tam;
   logic       onceki_tut = 1'b0;
   logic [7:0] onceki_pixel = 8'h00;
   logic       kabul;

   task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                          input logic [31:0] beklenen);
      n_karsilastirma++;
      if (gozlenen !== beklenen) begin
         n_hata++;
         $display("FAIL %s: gozlenen=0x%0h beklenen=0x%0h (cyc %0d)",
                  etiket, gozlenen, beklenen, cyc);
      end
   endtask

   function automatic logic [7:0] bellek_bayt(input logic [31:0] a);
      logic [7:0] h;
      h = a[15:8];
      return a[7:0] + h + h + h;
   endfunction

   function automatic logic [31:0] bellek_kelime(input logic [31:0] a);
      return {bellek_bayt(a + 32'd3), bellek_bayt(a + 32'd2),
              bellek_bayt(a + 32'd1), bellek_bayt(a)};
   endfunction

   // ---------------- memory, stall driver, monitor ----------------
   always @(negedge clk_i) begin
      if (!rstn_i) begin
         onceki_tut = 1'b0;
      end else begin
         bek = yanit_zaman_q.size();
         tam = teslim_sayisi - aktarim_sayisi / 4;

         case (stal_mod)
            1:       stal_i = cyc[0];
            2:       stal_i = ($urandom_range(0, 3) == 0);
            default: stal_i = 1'b0;
         endcase

         if (bek > 0 && yanit_zaman_q[0] == cyc) begin
            bel_veri_gecerli_i = 1'b1;
            bel_veri_i         = yanit_veri_q.pop_front();
            void'(yanit_zaman_q.pop_front());
         end else begin
            bel_veri_gecerli_i = 1'b0;
            bel_veri_i         = 32'hDEAD_BEEF;
         end

         kabul = 1'b0;
         if (bel_istek_o) begin
            istek_gorulen++;
            kabul = (kabul_mod == 0) || (istek_gorulen % 3 == 0);
            if (ilk_istek_cyc < 0) ilk_istek_cyc = cyc;
         end
         bel_istek_kabul_i = kabul;
         if (kabul) begin
            kontrol("bekleyen_siniri", 32'(bek + tam < 2), 32'd1);
            if (exp_adr_q.size() == 0) kontrol("fazla_istek", 32'd1, 32'd0);
            else kontrol("istek_adresi", bel_adres_o, exp_adr_q.pop_front());
            yanit_veri_q.push_back(bellek_kelime(bel_adres_o));
            yanit_zaman_q.push_back(cyc + gecikme);
         end

         if (basla_o) begin
            basla_sayisi++;
            basla_cyc = cyc;
            kontrol("basla_ile_etkin", 32'(etkin_o), 32'd0);
         end
         if (etkin_o && ilk_etkin_cyc < 0) ilk_etkin_cyc = cyc;

         if (onceki_tut) begin
            kontrol("stal_etkin_tut", 32'(etkin_o), 32'd1);
            kontrol("stal_pixel_tut", 32'(pixel_o), 32'(onceki_pixel));
         end

         if (mesgul_o && !basla_o && !etkin_o)
            kontrol("bosluk_tampon_bos", 32'(tam), 32'd0);

         if (etkin_o && stal_i) stal_model++;

         if (etkin_o && !stal_i) begin
            if (exp_q.size() == 0) kontrol("fazla_piksel", 32'd1, 32'd0);
            else kontrol("piksel", 32'(pixel_o), 32'(exp_q.pop_front()));
            aktarim_sayisi++;
            son_aktarim_cyc = cyc;
         end

         if (bitti_o) begin
            bitti_sayisi++;
            kontrol("bitti_zamani", 32'(cyc), 32'(son_aktarim_cyc + 1));
            kontrol("bitti_mesgul", 32'(mesgul_o), 32'd0);
         end

         if (bel_veri_gecerli_i) teslim_sayisi++;
         onceki_tut   = etkin_o && stal_i;
         onceki_pixel = pixel_o;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic kare_baslat(input logic [2:0] kod, input logic [31:0] taban);
      @(posedge clk_i); #1;
      for (int i = 0; i < TB_PIK; i++) exp_q.push_back(bellek_bayt(taban + 32'(i)));
      for (int k = 0; k < TB_KEL; k++) exp_adr_q.push_back(taban + 32'(4 * k));
      basla_sayisi    = 0;
      bitti_sayisi    = 0;
      aktarim_sayisi  = 0;
      teslim_sayisi   = 0;
      istek_gorulen   = 0;
      stal_model      = 0;
      ilk_istek_cyc   = -1;
      ilk_etkin_cyc   = -1;
      basla_cyc       = -1;
      son_aktarim_cyc = -1;
      baslat_cyc      = cyc;
      baslat_i        = 1'b1;
      gorev_kod_i     = kod;
      taban_adres_i   = taban;
      @(posedge clk_i); #1;
      baslat_i        = 1'b0;
      gorev_kod_i     = 3'd0;
      taban_adres_i   = 32'h0;
   endtask

   task automatic aktarim_bekle(input int n);
      for (int i = 0; i < 5000 && aktarim_sayisi < n; i++) @(posedge clk_i);
      kontrol("aktarim_zaman_asimi", 32'(aktarim_sayisi >= n), 32'd1);
   endtask

   task automatic bitti_bekle(input logic [2:0] kod);
      for (int i = 0; i < 5000 && bitti_sayisi == 0; i++) @(posedge clk_i);
      kontrol("bitti_zaman_asimi", 32'(bitti_sayisi > 0), 32'd1);
      repeat (4) @(posedge clk_i);
      #1;
      kontrol("bitti_sayisi", 32'(bitti_sayisi), 32'd1);
      kontrol("basla_sayisi", 32'(basla_sayisi), 32'd1);
      kontrol("kalan_piksel", 32'(exp_q.size()), 32'd0);
      kontrol("kalan_adres", 32'(exp_adr_q.size()), 32'd0);
      kontrol("aktarim_sayisi", 32'(aktarim_sayisi), 32'(TB_PIK));
      kontrol("gorev_tutulur", 32'(gorev_o), 32'(kod));
      kontrol("sonra_mesgul", 32'(mesgul_o), 32'd0);
      kontrol("sonra_istek", 32'(bel_istek_o), 32'd0);
`ifdef PIKSEL_BESLEYICI_SAYAC_EN
      kontrol("stal_sayac", stal_sayac_o, 32'(stal_model));
`endif
   endtask

   task automatic cikis_sifir_kontrol();
      kontrol("rst_mesgul", 32'(mesgul_o), 32'd0);
      kontrol("rst_bitti", 32'(bitti_o), 32'd0);
      kontrol("rst_istek", 32'(bel_istek_o), 32'd0);
      kontrol("rst_adres", bel_adres_o, 32'd0);
      kontrol("rst_basla", 32'(basla_o), 32'd0);
      kontrol("rst_gorev", 32'(gorev_o), 32'd0);
      kontrol("rst_etkin", 32'(etkin_o), 32'd0);
      kontrol("rst_pixel", 32'(pixel_o), 32'd0);
`ifdef PIKSEL_BESLEYICI_SAYAC_EN
      kontrol("rst_stal_sayac", stal_sayac_o, 32'd0);
`endif
   endtask

   task automatic model_temizle();
      exp_q.delete();
      exp_adr_q.delete();
      yanit_veri_q.delete();
      yanit_zaman_q.delete();
      bel_istek_kabul_i  = 1'b0;
      bel_veri_gecerli_i = 1'b0;
      bel_veri_i         = 32'h0;
   endtask

   // ---------------- sequence ----------------
   initial begin
      rstn_i             = 1'b0;
      baslat_i           = 1'b0;
      gorev_kod_i        = 3'd0;
      taban_adres_i      = 32'h0;
      stal_i             = 1'b0;
      bitti_sayisi       = 0;
      aktarim_sayisi     = 0;
      teslim_sayisi      = 0;
      model_temizle();
      repeat (3) @(posedge clk_i);
      #1;
      cikis_sifir_kontrol();
      rstn_i = 1'b1;
      repeat (2) @(posedge clk_i);

      // 1: zero-wait memory, no stall, latency and continuous stream
      stal_mod = 0; kabul_mod = 0; gecikme = 1;
      kare_baslat(GRV1_KOD, 32'h0000_0000);
      bitti_bekle(GRV1_KOD);
      kontrol("basla_gecikme", 32'(basla_cyc - baslat_cyc), 32'd1);
      kontrol("istek_gecikme", 32'(ilk_istek_cyc - baslat_cyc), 32'd2);
      kontrol("etkin_gecikme", 32'(ilk_etkin_cyc - baslat_cyc), 32'd4);
      kontrol("kesintisiz_akis", 32'(son_aktarim_cyc - ilk_etkin_cyc), 32'(TB_PIK - 1));

      // 2: stall every second cycle, ignored mid-frame start with GRV5
      stal_mod = 1;
      kare_baslat(GRV1_KOD, 32'h0000_0200);
      aktarim_bekle(20);
      @(posedge clk_i); #1;
      baslat_i = 1'b1; gorev_kod_i = GRV5_KOD; taban_adres_i = 32'h0000_5000;
      @(posedge clk_i); #1;
      baslat_i = 1'b0; gorev_kod_i = 3'd0; taban_adres_i = 32'h0;
      kontrol("gorev_degismez", 32'(gorev_o), 32'(GRV1_KOD));
      bitti_bekle(GRV1_KOD);

      // 3: slow memory, random stall, address wraps past 2^32
      stal_mod = 2; kabul_mod = 1; gecikme = 5;
      kare_baslat(GRV4_KOD, 32'hFFFF_FFC0);
      bitti_bekle(GRV4_KOD);

      // 4: reset mid-frame, then a fresh frame at 0x1000
      stal_mod = 0; kabul_mod = 0; gecikme = 1;
      kare_baslat(GRV2_KOD, 32'h0000_0000);
      aktarim_bekle(50);
      @(posedge clk_i); #1;
      rstn_i = 1'b0;
      #1;
      cikis_sifir_kontrol();
      model_temizle();
      @(posedge clk_i); #1;
      rstn_i = 1'b1;
      repeat (6) @(posedge clk_i);
      #1;
      kontrol("iptal_bitti_yok", 32'(bitti_sayisi), 32'd0);
      kontrol("iptal_sonra_mesgul", 32'(mesgul_o), 32'd0);
      kare_baslat(GRV3_KOD, 32'h0000_1000);
      bitti_bekle(GRV3_KOD);
      kontrol("yeni_kare_etkin_gecikme", 32'(ilk_etkin_cyc - baslat_cyc), 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_karsilastirma, n_hata);
      $finish;
   end

endmodule
